mini_fabric_egress_buf: RTL and testbench
=========================================

// Module: mini_fabric_egress_buf
// PURPOSE
//  Egress buffer between the mini_core tile memory wrapper and the router input port.
//  It captures every fabric transaction the tile emits: read responses and outgoing requests.
//  It holds them in a DEPTH-entry FIFO and presents them in order to the router over a valid/ready handshake.
//  The tile side has no backpressure, so overflow is detected, counted and flagged rather than stalled.
// PARAMETERS
//  DEPTH       4  FIFO entries; power of two, >= 2
//  AF_MARGIN   1  AlmostFull asserts when Count >= DEPTH-AF_MARGIN; range 0..DEPTH-1
//  DROP_CNT_W  8  width of DropCnt (saturating)
// PORTS
//  Clock                in   1                   tile clock
//  Rst                  in   1                   async reset, active-high
//  InFabricValidQ505H   in   1                   tile emits a transaction this cycle
//  InFabricQ505H        in   t_tile_trans        transaction from tile (opaque, stored whole)
//  OutFabricValid       out  1                   head entry valid toward router
//  OutFabric            out  t_tile_trans        head entry
//  OutFabricReady       in   1                   router accepts head this cycle
//  Count                out  $clog2(DEPTH)+1     current occupancy
//  AlmostFull           out  1                   Count >= DEPTH-AF_MARGIN
//  OverflowErr          out  1                   sticky: at least one transaction was dropped
//  DropCnt              out  DROP_CNT_W          number of dropped transactions, saturating
// BEHAVIOUR
//  - Reset, async on Rst rising: wr_ptr=rd_ptr=0; Count=0; OutFabricValid=0; AlmostFull=(AF_MARGIN==DEPTH? n/a:0);
//    OverflowErr=0; DropCnt=0. Storage contents are don't-care; OutFabric is unspecified while !OutFabricValid.
//  - Storage: DEPTH x $bits(t_tile_trans) register array; wr_ptr/rd_ptr are $clog2(DEPTH) bits and wrap naturally.
//  - push = InFabricValidQ505H. pop = OutFabricValid & OutFabricReady.
//  - Head is read combinationally from mem[rd_ptr]. OutFabricValid = (Count!=0), registered via Count.
//  - Latency: a push in cycle N into an empty buffer gives OutFabricValid=1 with that entry in cycle N+1.
//    There is no same-cycle bypass.
//  - Handshake: while OutFabricValid=1, OutFabric is held stable until popped. The router may hold Ready low indefinitely.
//    Ready while !OutFabricValid has no effect.
//  - Push accepted when Count<DEPTH, or when Count==DEPTH and pop is asserted in the same cycle (slot freed same edge).
//    An accepted push writes mem[wr_ptr] and increments wr_ptr.
//  - Pop increments rd_ptr.
//  - Count next = Count + accepted_push - pop; simultaneous push+pop leaves Count unchanged.
//  - Overflow: push while Count==DEPTH and !pop. The transaction is dropped: no write, pointers unchanged.
//    OverflowErr<=1 (cleared only by Rst). DropCnt increments and saturates at all-ones (never wraps).
//  - AlmostFull is combinational from registered Count.
//  - Reset mid-operation: all contents are discarded; OutFabricValid deasserts asynchronously with Rst.
//  - Order: strict FIFO with no reordering. Every accepted push is popped exactly once.
//  - Assertions: Count<=DEPTH at all times; OutFabric stable while (OutFabricValid & !OutFabricReady).
// TESTING
//  1. Single pass: Ready=1, push T0 at cycle 5 -> OutFabricValid=1, OutFabric=T0 at cycle 6.
//     Popped at cycle 6; Count back to 0 at cycle 7.
//  2. Fill/drain: Ready=0, push T0..T3 on consecutive cycles -> Count=4, AlmostFull=1 after the 3rd push.
//     Then Ready=1 for 4 cycles -> T0,T1,T2,T3 emitted in order; Count=0; OverflowErr=0.
//  3. Overflow: full (DEPTH=4), Ready=0, push T4,T5 -> both dropped, DropCnt=2, OverflowErr=1.
//     Drain -> only T0..T3 seen.
//  4. Full with simultaneous push+pop: Count=4, Ready=1, push T4 -> T0 popped, T4 accepted.
//     Count stays 4; DropCnt unchanged; T4 emitted after T3.
//  5. Backpressure stability plus wrap: 10 random-gap pushes with random Ready.
//     Scoreboard order matches; OutFabric is stable while stalled; pointers wrap past DEPTH correctly.
//  6. Reset mid-traffic: Count=3, assert Rst for 1 cycle.
//     OutFabricValid=0, Count=0 and DropCnt=0 immediately; next push is emitted as the first entry.

Source files
------------

// File: rtl/mini_fabric_egress_buf_if.sv
//------------------------------------------------------------------------------
// Module : mini_fabric_egress_buf_if
// Brief  : Tile-to-buffer push bus and buffer-to-router valid/ready handshake.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

interface mini_fabric_egress_buf_if #(
  parameter int TRANS_W = 32
);
  logic               InFabricValidQ505H;
  logic [TRANS_W-1:0] InFabricQ505H;
  logic               OutFabricValid;
  logic [TRANS_W-1:0] OutFabric;
  logic               OutFabricReady;

  // Master is the environment: tile driving pushes and router driving Ready.
  modport master (
    output InFabricValidQ505H, InFabricQ505H, OutFabricReady,
    input  OutFabricValid, OutFabric
  );

  modport slave (
    input  InFabricValidQ505H, InFabricQ505H, OutFabricReady,
    output OutFabricValid, OutFabric
  );
endinterface

`default_nettype wire

// File: rtl/mini_fabric_egress_buf.sv
//------------------------------------------------------------------------------
// Module : mini_fabric_egress_buf
// Brief  : FIFO between the tile and the router; drops and counts on overflow.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module mini_fabric_egress_buf #(
  parameter int TRANS_W    = 32,
  parameter int DEPTH      = 4,
  parameter int AF_MARGIN  = 1,
  parameter int DROP_CNT_W = 8
) (
  input  wire logic                       Clock,
  input  wire logic                       Rst,
  mini_fabric_egress_buf_if.slave         fab,
  output logic [$clog2(DEPTH):0]          Count,
  output logic                            AlmostFull,
  output logic                            OverflowErr,
  output logic [DROP_CNT_W-1:0]           DropCnt
);

  localparam int                 c_ptrW    = $clog2(DEPTH);
  localparam int                 c_cntW    = c_ptrW + 1;
  localparam logic [c_cntW-1:0]  c_depth   = c_cntW'(DEPTH);
  localparam logic [c_cntW-1:0]  c_afLevel = c_cntW'(DEPTH - AF_MARGIN);

  logic [TRANS_W-1:0]    r_mem [DEPTH];
  logic [c_ptrW-1:0]     r_wrPtr;
  logic [c_ptrW-1:0]     r_rdPtr;
  logic [c_cntW-1:0]     r_count;
  logic                  r_overflowErr;
  logic [DROP_CNT_W-1:0] r_dropCnt;

  logic w_full;
  logic w_pop;
  logic w_pushAcc;
  logic w_drop;

  assign w_full    = (r_count == c_depth);
  assign w_pop     = fab.OutFabricValid & fab.OutFabricReady;
  // A full buffer still accepts when the head leaves on the same edge.
  assign w_pushAcc = fab.InFabricValidQ505H & (~w_full | w_pop);
  assign w_drop    = fab.InFabricValidQ505H & w_full & ~w_pop;

  assign fab.OutFabricValid = (r_count != '0);
  assign fab.OutFabric      = r_mem[r_rdPtr];
  assign Count              = r_count;
  assign AlmostFull         = (r_count >= c_afLevel);
  assign OverflowErr        = r_overflowErr;
  assign DropCnt            = r_dropCnt;

  always_ff @(posedge Clock) begin
    if (w_pushAcc) begin
      r_mem[r_wrPtr] <= fab.InFabricQ505H;
    end
  end

  always_ff @(posedge Clock or posedge Rst) begin
    if (Rst) begin
      r_wrPtr       <= '0;
      r_rdPtr       <= '0;
      r_count       <= '0;
      r_overflowErr <= 1'b0;
      r_dropCnt     <= '0;
    end else begin
      if (w_pushAcc) r_wrPtr <= r_wrPtr + 1'b1;
      if (w_pop)     r_rdPtr <= r_rdPtr + 1'b1;
      case ({w_pushAcc, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (w_drop) begin
        r_overflowErr <= 1'b1;
        if (r_dropCnt != '1) r_dropCnt <= r_dropCnt + 1'b1;
      end
    end
  end

  a_countBound: assert property (@(posedge Clock) disable iff (Rst)
    r_count <= c_depth);

  a_headStable: assert property (@(posedge Clock) disable iff (Rst)
    (fab.OutFabricValid & ~fab.OutFabricReady) |=> $stable(fab.OutFabric));

endmodule

`default_nettype wire

// File: tb/tb_mini_fabric_egress_buf.sv
//------------------------------------------------------------------------------
// Module : tb_mini_fabric_egress_buf
// Brief  : Directed checks of mini_fabric_egress_buf with DEPTH=4, AF_MARGIN=1.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_mini_fabric_egress_buf;

  localparam int TRANS_W = 16;

  logic        clk;
  logic        rst;
  logic [2:0]  cnt;
  logic        af;
  logic        oerr;
  logic [7:0]  dcnt;

  int compared   = 0;
  int mismatched = 0;

  mini_fabric_egress_buf_if #(.TRANS_W(TRANS_W)) fab ();

  mini_fabric_egress_buf #(
    .TRANS_W(TRANS_W), .DEPTH(4), .AF_MARGIN(1), .DROP_CNT_W(8)
  ) dut (
    .Clock      (clk),
    .Rst        (rst),
    .fab        (fab),
    .Count      (cnt),
    .AlmostFull (af),
    .OverflowErr(oerr),
    .DropCnt    (dcnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [15:0] d);
    fab.InFabricValidQ505H = 1'b1;
    fab.InFabricQ505H      = d;
    tick();
    fab.InFabricValidQ505H = 1'b0;
  endtask

  task automatic drainExpect(input logic [15:0] first, input int n, input string tag);
    fab.OutFabricReady = 1'b1;
    for (int i = 0; i < n; i++) begin
      chk({tag, "_valid"}, 32'(fab.OutFabricValid), 32'd1);
      chk({tag, "_data"}, 32'(fab.OutFabric), 32'(first + 16'(i)));
      tick();
    end
    fab.OutFabricReady = 1'b0;
    chk({tag, "_empty"}, 32'(cnt), 32'd0);
  endtask

  logic [15:0] q[$];
  logic [15:0] prevHead;
  logic        prevStall;
  int          pushed;
  int          cycles;
  logic        doPush;
  logic        doReady;
  logic        mPop;

  initial begin
    rst = 1'b1;
    fab.InFabricValidQ505H = 1'b0;
    fab.InFabricQ505H      = '0;
    fab.OutFabricReady     = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    tick();

    // Reset state
    chk("rst_count", 32'(cnt), 32'd0);
    chk("rst_valid", 32'(fab.OutFabricValid), 32'd0);
    chk("rst_af", 32'(af), 32'd0);
    chk("rst_oerr", 32'(oerr), 32'd0);
    chk("rst_dcnt", 32'(dcnt), 32'd0);

    // 1: single pass, one-cycle latency
    fab.OutFabricReady = 1'b1;
    chk("t1_prevalid", 32'(fab.OutFabricValid), 32'd0);
    push(16'hA000);
    chk("t1_valid", 32'(fab.OutFabricValid), 32'd1);
    chk("t1_data", 32'(fab.OutFabric), 32'hA000);
    chk("t1_count1", 32'(cnt), 32'd1);
    tick();
    chk("t1_count0", 32'(cnt), 32'd0);
    chk("t1_valid0", 32'(fab.OutFabricValid), 32'd0);

    // 2: fill then drain
    fab.OutFabricReady = 1'b0;
    push(16'hB000);
    push(16'hB001);
    chk("t2_af_at2", 32'(af), 32'd0);
    push(16'hB002);
    chk("t2_af_at3", 32'(af), 32'd1);
    chk("t2_count3", 32'(cnt), 32'd3);
    push(16'hB003);
    chk("t2_count4", 32'(cnt), 32'd4);
    chk("t2_head", 32'(fab.OutFabric), 32'hB000);
    drainExpect(16'hB000, 4, "t2");
    chk("t2_oerr", 32'(oerr), 32'd0);

    // 3: overflow drops while stalled
    for (int i = 0; i < 4; i++) push(16'hC000 + 16'(i));
    push(16'hC004);
    push(16'hC005);
    chk("t3_count", 32'(cnt), 32'd4);
    chk("t3_dcnt", 32'(dcnt), 32'd2);
    chk("t3_oerr", 32'(oerr), 32'd1);
    drainExpect(16'hC000, 4, "t3");

    // 4: full with simultaneous push and pop
    for (int i = 0; i < 4; i++) push(16'hD000 + 16'(i));
    fab.OutFabricReady = 1'b1;
    push(16'hD004);
    fab.OutFabricReady = 1'b0;
    chk("t4_count", 32'(cnt), 32'd4);
    chk("t4_dcnt", 32'(dcnt), 32'd2);
    chk("t4_head", 32'(fab.OutFabric), 32'hD001);
    drainExpect(16'hD001, 4, "t4");

    // 5: random gaps and random Ready against a queue model
    pushed    = 0;
    cycles    = 0;
    prevStall = 1'b0;
    prevHead  = '0;
    q.delete();
    while ((pushed < 10 || q.size() != 0) && cycles < 300) begin
      chk("t5_count", 32'(cnt), 32'(q.size()));
      chk("t5_valid", 32'(fab.OutFabricValid), 32'(q.size() != 0));
      if (q.size() != 0) chk("t5_head", 32'(fab.OutFabric), 32'(q[0]));
      if (prevStall) chk("t5_stable", 32'(fab.OutFabric), 32'(prevHead));
      doPush  = (pushed < 10) && ($urandom_range(0, 2) != 0);
      doReady = ($urandom_range(0, 1) == 1);
      fab.InFabricValidQ505H = doPush;
      fab.InFabricQ505H      = 16'hE000 + 16'(pushed);
      fab.OutFabricReady     = doReady;
      mPop      = (q.size() != 0) && doReady;
      prevStall = (q.size() != 0) && !doReady;
      prevHead  = fab.OutFabric;
      if (doPush && (q.size() < 4 || mPop)) begin
        if (mPop) void'(q.pop_front());
        q.push_back(16'hE000 + 16'(pushed));
      end else if (mPop) begin
        void'(q.pop_front());
      end
      if (doPush) pushed++;
      tick();
      cycles++;
    end
    fab.InFabricValidQ505H = 1'b0;
    fab.OutFabricReady     = 1'b0;
    chk("t5_bound", 32'(cycles < 300), 32'd1);
    chk("t5_done", 32'(cnt), 32'(q.size()));

    // DropCnt saturation
    for (int i = 0; i < 4; i++) push(16'hF000 + 16'(i));
    fab.InFabricValidQ505H = 1'b1;
    for (int i = 0; i < 300; i++) tick();
    fab.InFabricValidQ505H = 1'b0;
    chk("sat_dcnt", 32'(dcnt), 32'hFF);
    chk("sat_count", 32'(cnt), 32'd4);
    chk("sat_head", 32'(fab.OutFabric), 32'hF000);

    // 6: reset mid-traffic, asynchronous effect
    fab.OutFabricReady = 1'b1;
    tick();
    fab.OutFabricReady = 1'b0;
    chk("t6_count3", 32'(cnt), 32'd3);
    #2;
    rst = 1'b1;
    #1;
    chk("t6_async_valid", 32'(fab.OutFabricValid), 32'd0);
    chk("t6_async_count", 32'(cnt), 32'd0);
    chk("t6_async_dcnt", 32'(dcnt), 32'd0);
    chk("t6_async_oerr", 32'(oerr), 32'd0);
    tick();
    rst = 1'b0;
    push(16'h9999);
    chk("t6_first_valid", 32'(fab.OutFabricValid), 32'd1);
    chk("t6_first_data", 32'(fab.OutFabric), 32'h9999);
    chk("t6_first_count", 32'(cnt), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

`default_nettype wire
